gc_refresh_arbiter: RTL
=======================

Name: gc_refresh_arbiter

Overview:
Shares the single gain-cell DRAM array port between a host requester and the refresh engine. It consumes the one-cycle refresh-interval tick and queues it as a pending full-array sweep. Each sweep is executed row by row as a read followed by a write-back, and host accesses are interleaved between rows. When pending sweeps reach an urgency threshold, the block stalls the host to guarantee retention.

Parameters:
ROWS, 64, number of array rows per sweep (power of 2)
DATA_W, 32, row/word width
MAX_PENDING, 4, maximum queued sweeps; further ticks are dropped
URGENT_TH, 2, pend_cnt at or above which refresh preempts the host
ADDR_W, $clog2(ROWS), row address width (derived)
PEND_W, $clog2(MAX_PENDING+1), pending counter width (derived)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
ref_tick  in  1  one-cycle pulse from the refresh interval counter
disable_ref  in  1  freeze refresh: ignore ticks, start no new rows
host_req  in  1  host access request, held until granted
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host row address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  combinational grant, same cycle as the accepted request
host_rvalid  out  1  registered; high 1 cycle after a granted read
host_rdata  out  DATA_W  equal to mem_rdata (valid when host_rvalid=1)
mem_en  out  1  array access strobe
mem_we  out  1  array write enable
mem_addr  out  ADDR_W  array row address
mem_wdata  out  DATA_W  array write data
mem_rdata  in  DATA_W  array read data, valid 1 cycle after a read
ref_busy  out  1  high while a sweep is in progress (row_cnt != 0 or state is REF_RD/REF_WR)
pend_cnt  out  PEND_W  queued sweeps not yet completed
overflow  out  1  sticky; set when a tick is dropped

Behaviour:
- Reset (sync): state=IDLE, row_cnt=0, pend_cnt=0, overflow=0, host_rvalid=0, all mem_* outputs 0, host_gnt=0.
- FSM states are IDLE, REF_RD and REF_WR. Host accesses complete in IDLE and take no extra state.
- Arbitration applies in IDLE only.
  - refresh_sel = pend_cnt>0 && !disable_ref && (pend_cnt>=URGENT_TH || !host_req).
  - If refresh_sel: go to REF_RD, host_gnt=0.
  - Else if host_req: host_gnt=1, mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata; stay in IDLE. Back-to-back host grants are allowed.
- REF_RD: mem_en=1, mem_we=0, mem_addr=row_cnt; then go to REF_WR.
- REF_WR: mem_en=1, mem_we=1, mem_addr=row_cnt, mem_wdata=mem_rdata.
  - Increment row_cnt modulo ROWS.
  - On the wrap ROWS-1 -> 0, decrement pend_cnt (sweep complete).
  - Next state is IDLE, so the host can win between rows.
- Each refreshed row costs 2 cycles. An uncontended sweep takes 2*ROWS cycles plus ROWS IDLE arbitration cycles. Refresh always enters through IDLE, so this is 3*ROWS cycles total.
- host_rvalid is registered: it equals (host_gnt && !host_we) from the previous cycle.
- A host read granted in cycle N followed by REF_RD in N+1 is legal. Data in N+1 belongs to the host, and data in N+2 belongs to refresh.
- Tick handling (ignored when disable_ref=1):
  - If pend_cnt<MAX_PENDING, increment pend_cnt.
  - Otherwise the tick is dropped and overflow<=1. Overflow clears only on reset.
- Simultaneous tick and sweep completion: pend_cnt is unchanged. If pend_cnt was MAX_PENDING, there is no overflow, because the completion frees the slot in the same cycle.
- disable_ref asserted in REF_RD: REF_WR still completes (a row is never left read-but-unrestored). No new REF_RD starts. row_cnt and pend_cnt are held, and the sweep resumes at the same row when disable_ref deasserts.
- Host request while in REF_RD/REF_WR: host_gnt=0. The request is held by the host and re-arbitrated in IDLE.
- Reset mid-sweep: all progress is discarded, including row_cnt and pend_cnt.

Optional Feature:
GC_REF_STATS_EN adds two output ports:
- sweep_done_cnt (16 bits): completed sweeps, saturating.
- urgent_stall_cnt (16 bits): cycles with host_req=1 && refresh_sel=1 && pend_cnt>=URGENT_TH, saturating.
Both reset to 0. Without the macro, neither port nor its logic exists, and all other behaviour is identical.

Decomposition:
- Package gc_ref_pkg holds:
  - the state enum (IDLE, REF_RD, REF_WR);
  - default constants for ROWS, MAX_PENDING and URGENT_TH;
  - the statistics counter width of 16.
- Sub-module ref_row_counter holds row_cnt with enable, hold and a wrap pulse output. The wrap pulse drives the pend_cnt decrement.

Test Plan:
- Single tick, host idle (ROWS=4) -> pend_cnt 0->1, then 4 REF_RD/REF_WR pairs on rows 0..3, each write-back data equal to the preceding read, then pend_cnt=0 and ref_busy=0.
- Continuous host_req, pend_cnt=1 -> host is granted every cycle and no refresh occurs. A second tick raises pend_cnt to 2, refresh preempts, and one row pair is interleaved per IDLE arbitration.
- Five ticks with disable_ref=0 and refresh blocked by host traffic at pend_cnt<URGENT_TH (set URGENT_TH=5) -> pend_cnt saturates at 4 and overflow=1 on the 5th tick.
- Tick in the same cycle as the REF_WR of row ROWS-1 with pend_cnt=4 -> pend_cnt stays 4 and overflow stays 0.
- disable_ref raised during REF_RD of row 2 -> REF_WR row 2 completes, then host-only service with row_cnt=3 held. On release, refresh resumes at row 3.
- Host read of row 5 immediately followed by REF_RD -> host_rvalid in the next cycle with row-5 data, and the refresh write-back uses the following cycle's rdata.

Source files
------------

// File: rtl/gc_ref_pkg.sv
// Shared types and defaults for the gain-cell refresh arbiter.
// The state enum, default geometry and statistics counter width live here.
package gc_ref_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REF_RD = 2'd1,
        REF_WR = 2'd2
    } ref_state_e;

    localparam int unsigned ROWS_DEF        = 64;
    localparam int unsigned MAX_PENDING_DEF = 4;
    localparam int unsigned URGENT_TH_DEF   = 2;
    localparam int unsigned STAT_W          = 16;

endpackage

// File: rtl/ref_row_counter.sv
// Refresh row pointer: advances once per restored row and pulses o_wrap on the
// last row of a sweep. It holds its value whenever i_en is low.
module ref_row_counter #(
    parameter int unsigned ROWS   = 64,
    parameter int unsigned ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_row,
    output logic              o_wrap
);

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(ROWS - 1);

    logic [ADDR_W-1:0] r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
        end else if (i_en) begin
            r_row <= (r_row == LP_LAST) ? '0 : r_row + ADDR_W'(1);
        end
    end

    assign o_row  = r_row;
    assign o_wrap = i_en && (r_row == LP_LAST);

endmodule

// File: rtl/gc_refresh_arbiter.sv
// Arbitrates the single gain-cell array port between host accesses and row-by-row
// refresh sweeps. Optional statistics ports are built when GC_REF_STATS_EN is defined.
module gc_refresh_arbiter
    import gc_ref_pkg::*;
#(
    parameter int unsigned ROWS        = ROWS_DEF,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_PENDING = MAX_PENDING_DEF,
    parameter int unsigned URGENT_TH   = URGENT_TH_DEF,
    parameter int unsigned ADDR_W      = $clog2(ROWS),
    parameter int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_tick,
    input  logic              disable_ref,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ref_busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
`ifdef GC_REF_STATS_EN
    ,
    output logic [STAT_W-1:0] sweep_done_cnt,
    output logic [STAT_W-1:0] urgent_stall_cnt
`endif
);

    localparam logic [PEND_W-1:0] LP_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] LP_URG = PEND_W'(URGENT_TH);

    ref_state_e        r_state;
    ref_state_e        w_state_nxt;
    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;
    logic              r_rvalid;
    logic [ADDR_W-1:0] w_row;
    logic              w_row_en;
    logic              w_wrap;
    logic              w_refresh_sel;
    logic              w_tick_acc;
    logic              w_gnt;

    ref_row_counter #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_row_en),
        .o_row  (w_row),
        .o_wrap (w_wrap)
    );

    assign w_refresh_sel = (r_state == IDLE) && (r_pend != '0) && !disable_ref &&
                           ((r_pend >= LP_URG) || !host_req);

    // Outputs are forced low while rst is held, before the state register clears.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_row_en    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (w_refresh_sel) begin
                        w_state_nxt = REF_RD;
                    end else if (host_req) begin
                        w_gnt     = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = host_we;
                        mem_addr  = host_addr;
                        mem_wdata = host_wdata;
                    end
                end
                REF_RD: begin
                    mem_en      = 1'b1;
                    mem_addr    = w_row;
                    w_state_nxt = REF_WR;
                end
                REF_WR: begin
                    // Write-back always completes, even under disable_ref.
                    mem_en      = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = w_row;
                    mem_wdata   = mem_rdata;
                    w_row_en    = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_tick_acc = ref_tick && !disable_ref;

    // A tick landing on a sweep completion reuses the freed slot: no change, no overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else if (w_tick_acc && !w_wrap) begin
            if (r_pend < LP_MAX) begin
                r_pend <= r_pend + PEND_W'(1);
            end else begin
                r_ovf <= 1'b1;
            end
        end else if (!w_tick_acc && w_wrap) begin
            r_pend <= r_pend - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_gnt && !host_we;
        end
    end

    assign host_gnt    = w_gnt;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = mem_rdata;
    assign ref_busy    = (w_row != '0) || (r_state != IDLE);
    assign pend_cnt    = r_pend;
    assign overflow    = r_ovf;

`ifdef GC_REF_STATS_EN
    logic [STAT_W-1:0] r_sweep_cnt;
    logic [STAT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_wrap && (r_sweep_cnt != '1)) begin
                r_sweep_cnt <= r_sweep_cnt + STAT_W'(1);
            end
            if (host_req && w_refresh_sel && (r_pend >= LP_URG) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            end
        end
    end

    assign sweep_done_cnt   = r_sweep_cnt;
    assign urgent_stall_cnt = r_stall_cnt;
`endif

endmodule
